// File: rtl/cordic_iter_ctrl.sv
// Iteration sequencer for the CORDIC rotation datapath: loads the target angle, steps the
// arctan LUT index and tracks the residual angle z. Optional macro CORDIC_ABORT_EN adds abort_in.
module cordic_iter_ctrl #(
  parameter int ITERATIONS = 8,
  parameter int CNT_W      = 3,
  parameter int DATA_W     = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [DATA_W-1:0] z_init_in,
  input  logic [DATA_W-1:0] lut_data_in,
`ifdef CORDIC_ABORT_EN
  input  logic              abort_in,
`endif
  output logic [CNT_W-1:0]  lut_addr_out,
  output logic              load_en_out,
  output logic              iter_en_out,
  output logic              dir_out,
  output logic              busy_out,
  output logic              done_out,
  output logic [DATA_W-1:0] z_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERATIONS - 1);

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          count;
  logic signed [DATA_W-1:0]  z;
  logic                      abort_req;
  logic                      last_iter;

`ifdef CORDIC_ABORT_EN
  assign abort_req = abort_in;
`else
  assign abort_req = 1'b0;
`endif

  // One micro-rotation on the residual angle; wraps modulo 2**DATA_W, never saturates.
  function automatic logic signed [DATA_W-1:0] z_step(
    input logic signed [DATA_W-1:0] z_cur,
    input logic        [DATA_W-1:0] atan_val,
    input logic                     dir
  );
    logic signed [DATA_W-1:0] a;
    a = signed'(atan_val);
    return dir ? (z_cur - a) : (z_cur + a);
  endfunction

  assign last_iter = (count == LAST_CNT);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_in) state_nxt = LOAD;
      LOAD: state_nxt = abort_req ? IDLE : ITER;
      ITER: begin
        if (abort_req)      state_nxt = IDLE;
        else if (last_iter) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Residual angle and iteration index; both cleared by reset and by abort.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count <= '0;
      z     <= '0;
    end else begin
      case (state)
        LOAD: begin
          count <= '0;
          z     <= abort_req ? '0 : signed'(z_init_in);
        end
        ITER: begin
          if (abort_req) begin
            count <= '0;
            z     <= '0;
          end else begin
            count <= last_iter ? '0 : count + CNT_W'(1);
            z     <= z_step(z, lut_data_in, dir_out);
          end
        end
        default: begin
          count <= count;
          z     <= z;
        end
      endcase
    end
  end

  assign load_en_out  = (state == LOAD);
  assign iter_en_out  = (state == ITER);
  assign busy_out     = (state != IDLE);
  assign done_out     = (state == DONE);
  assign lut_addr_out = iter_en_out ? count : '0;
  assign dir_out      = iter_en_out & ~z[DATA_W-1];
  assign z_out        = z;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Self-checking bench for cordic_iter_ctrl; builds with or without CORDIC_ABORT_EN.
module tb_cordic_iter_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] z_init = 8'd0;
  logic [7:0] lut_data;
  logic [2:0] lut_addr;
  logic       load_en, iter_en, dir, busy, done;
  logic [7:0] z_out;
`ifdef CORDIC_ABORT_EN
  logic       abort = 1'b0;
`endif

  int vectors = 0;
  int errors  = 0;

  logic [7:0] lut_rom [8] = '{8'd32, 8'd19, 8'd10, 8'd5, 8'd3, 8'd1, 8'd1, 8'd0};
  assign lut_data = lut_rom[lut_addr];

  always #5 clk = ~clk;

  cordic_iter_ctrl #(.ITERATIONS(8), .CNT_W(3), .DATA_W(8)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .start_in     (start),
    .z_init_in    (z_init),
    .lut_data_in  (lut_data),
`ifdef CORDIC_ABORT_EN
    .abort_in     (abort),
`endif
    .lut_addr_out (lut_addr),
    .load_en_out  (load_en),
    .iter_en_out  (iter_en),
    .dir_out      (dir),
    .busy_out     (busy),
    .done_out     (done),
    .z_out        (z_out)
  );

  // Reference: plain integer CORDIC angle recursion, wrapped back into signed 8-bit range.
  task automatic model_run(input logic [7:0] z0, output logic [7:0] dirs, output logic [7:0] zf);
    int z;
    int lut_val [8] = '{32, 19, 10, 5, 3, 1, 1, 0};
    z = int'($signed(z0));
    for (int i = 0; i < 8; i++) begin
      if (z >= 0) begin dirs[i] = 1'b1; z = z - lut_val[i]; end
      else        begin dirs[i] = 1'b0; z = z + lut_val[i]; end
      if (z > 127)  z = z - 256;
      if (z < -128) z = z + 256;
    end
    zf = 8'(z);
  endtask

  function automatic logic [7:0] obs_vec();
    return {load_en, iter_en, dir, busy, done, lut_addr};
  endfunction

  // Full run: cycle k counts from the cycle after the start edge (k=1 is LOAD, k=10 is DONE).
  task automatic run_and_check(input logic [7:0] z0, input string name);
    logic [7:0] dirs, zf, exp;
    bit is_iter;
    model_run(z0, dirs, zf);
    @(negedge clk);
    start = 1'b1; z_init = z0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) @(negedge clk);
      is_iter = (k >= 2 && k <= 9);
      exp = {k == 1, is_iter, is_iter ? dirs[(k-2) & 7] : 1'b0, k <= 10, k == 10,
             is_iter ? 3'(k-2) : 3'd0};
      vectors++;
      if (obs_vec() !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d ctrl {ld,it,dir,busy,done,addr} got %b want %b", name, k, obs_vec(), exp);
      end
      if (k >= 10) begin
        vectors++;
        if (z_out !== zf) begin
          errors++;
          $display("FAIL %s z_out cycle %0d got %h want %h", name, k, z_out, zf);
        end
      end
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (obs_vec() !== 8'd0 || z_out !== 8'd0) begin
      errors++;
      $display("FAIL reset_initial got %b/%h want 0/00", obs_vec(), z_out);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); start = 1'b1; z_init = 8'h55;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (obs_vec() !== 8'd0 || z_out !== 8'd0) begin
      errors++;
      $display("FAIL reset_async got %b/%h want 0/00", obs_vec(), z_out);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    run_and_check(8'd32, "basic32");
    run_and_check(8'h80, "wrap80");
    run_and_check(8'h7F, "pos7F");
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) run_and_check(8'($urandom_range(0, 255)), "random");
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    bit idle_ok = 1'b1;
    @(negedge clk); start = 1'b1; z_init = 8'd40;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) @(negedge clk);
      if (done) dones++;
      if (k >= 11 && busy) idle_ok = 1'b0;
      start = (k == 4 || k == 10);
    end
    start = 1'b0;
    vectors++;
    if (dones !== 1 || !idle_ok) begin
      errors++;
      $display("FAIL ignore_start dones %0d idle_ok %0d want 1 1", dones, idle_ok);
    end
  endtask

  task automatic test_back_to_back();
    int loads [$];
    @(negedge clk); start = 1'b1; z_init = 8'd20;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (load_en) loads.push_back(k);
    end
    start = 1'b0;
    repeat (14) @(negedge clk);
    vectors++;
    if (loads.size() < 3 || loads[1] - loads[0] != 11 || loads[2] - loads[1] != 11) begin
      errors++;
      $display("FAIL back_to_back load spacing got %0d loads, first at %0d want spacing 11",
               loads.size(), loads.size() > 0 ? loads[0] : -1);
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back settle busy got %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen_done = 1'b0;
    @(negedge clk); start = 1'b1; z_init = 8'd32;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (lut_addr !== 3'd4 || iter_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid position addr %0d iter %b want 4 1", lut_addr, iter_en);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (obs_vec() !== 8'd0 || z_out !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid outputs got %b/%h want 0/00", obs_vec(), z_out);
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    vectors++;
    if (seen_done) begin
      errors++;
      $display("FAIL rst_mid activity after reset got 1 want 0");
    end
    run_and_check(8'd32, "after_rst");
  endtask

`ifdef CORDIC_ABORT_EN
  task automatic test_abort(input int at_iter);
    bit seen = 1'b0;
    @(negedge clk); start = 1'b1; z_init = 8'd32;
    @(negedge clk); start = 1'b0;
    repeat (at_iter + 1) @(negedge clk);
    vectors++;
    if (lut_addr !== 3'(at_iter)) begin
      errors++;
      $display("FAIL abort position addr %0d want %0d", lut_addr, at_iter);
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    vectors++;
    if (obs_vec() !== 8'd0 || z_out !== 8'd0) begin
      errors++;
      $display("FAIL abort_%0d state got %b/%h want 0/00", at_iter, obs_vec(), z_out);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      errors++;
      $display("FAIL abort_%0d activity after abort got 1 want 0", at_iter);
    end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_basic();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
`ifdef CORDIC_ABORT_EN
    test_abort(3);
    test_abort(7);
    run_and_check(8'd32, "after_abort");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
